// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates one signed weighted sum per
// accepted step, leaks by a right shift, fires at threshold and then ignores
// REFRAC accepted steps. Runs for TSTEPS accepted steps per inference window.
module lif_neuron #(
    parameter int IN_WIDTH   = 8,
    parameter int POT_WIDTH  = 12,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int TSTEPS     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           sum_valid,
    input  logic [IN_WIDTH-1:0]            sum_in,
    output logic                           sum_ready,
    output logic                           spike,
    output logic                           spike_valid,
    output logic [$clog2(TSTEPS+1)-1:0]    spike_count,
    output logic                           busy,
    output logic                           done,
    output logic [POT_WIDTH-1:0]           potential
);

    localparam int CW = $clog2(TSTEPS + 1);
    localparam int RW = $clog2(REFRAC + 2);
    localparam int TW = POT_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]        step_cnt;
    logic [RW-1:0]        refrac_cnt;
    logic                 accept;
    logic                 last_step;
    logic [POT_WIDTH-1:0] leak;
    logic [TW-1:0]        t_sum;
    logic [POT_WIDTH-1:0] v_new;
    logic                 fire;

    assign sum_ready = (state == RUN) & ~start;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = sum_valid & sum_ready;
    assign last_step = (step_cnt == CW'(TSTEPS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start restarts from any state; DONE lasts one cycle
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                RUN:  if (accept && last_step) state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Membrane update: leak, add sign-extended sum, clamp to 0..max, threshold
    always_comb begin
        leak = '0;
        if (LEAK_SHIFT != 0) begin
            leak = potential >> LEAK_SHIFT;
        end
        // Two guard bits: the top bit flags a negative result, the next an overflow
        t_sum = {2'b00, potential} - {2'b00, leak}
              + {{(TW - IN_WIDTH){sum_in[IN_WIDTH-1]}}, sum_in};
        if (t_sum[TW-1]) begin
            v_new = '0;
        end else if (t_sum[TW-2]) begin
            v_new = '1;
        end else begin
            v_new = t_sum[POT_WIDTH-1:0];
        end
        fire = (v_new >= POT_WIDTH'(THRESH));
    end

    // Step, refractory, potential and spike registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            potential   <= '0;
            step_cnt    <= '0;
            refrac_cnt  <= '0;
            spike_count <= '0;
            spike       <= 1'b0;
            spike_valid <= 1'b0;
        end else if (start) begin
            potential   <= '0;
            step_cnt    <= '0;
            refrac_cnt  <= '0;
            spike_count <= '0;
            spike       <= 1'b0;
            spike_valid <= 1'b0;
        end else begin
            spike_valid <= accept;
            if (accept) begin
                step_cnt <= step_cnt + 1'b1;
                if (refrac_cnt != '0) begin
                    refrac_cnt <= refrac_cnt - 1'b1;
                    potential  <= '0;
                    spike      <= 1'b0;
                end else if (fire) begin
                    potential  <= '0;
                    spike      <= 1'b1;
                    refrac_cnt <= RW'(REFRAC);
                    if (spike_count != CW'(TSTEPS)) begin
                        spike_count <= spike_count + 1'b1;
                    end
                end else begin
                    potential <= v_new;
                    spike     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron that consumes the 8-bit weighted sums produced by the layer's multiply-accumulate datapath. It integrates one sum per time step, leaks, fires, and enforces a refractory period. It emits a spike bit per time step, which is the pixel input for the next layer's MAC. One instance sits behind each MAC output and is run for a fixed window of time steps per inference.

## Interface
- IN_WIDTH, 8: width of `sum_in`, signed two's complement.
- POT_WIDTH, 12: membrane potential width, unsigned, range 0..2^POT_WIDTH-1.
- THRESH, 64: firing threshold; fire when the updated potential is >= THRESH.
- LEAK_SHIFT, 3: leak per step is `v >> LEAK_SHIFT`; a value of 0 disables leak.
- REFRAC, 2: number of accepted steps ignored after a spike.
- TSTEPS, 16: accepted steps per inference window.

Ports:
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `start` input, 1 bit: begin a new inference window; valid in any state.
- `sum_valid` input, 1 bit: `sum_in` is valid.
- `sum_in` input, IN_WIDTH bits: signed weighted sum for this step.
- `sum_ready` output, 1 bit: combinational, equal to (state==RUN) & ~start.
- `spike` output, 1 bit: registered; the spike result of the last accepted step.
- `spike_valid` output, 1 bit: registered; 1-cycle pulse per accepted step.
- `spike_count` output, $clog2(TSTEPS+1) bits: spikes emitted in the current window.
- `busy` output, 1 bit: state==RUN.
- `done` output, 1 bit: 1-cycle pulse when the window completes.
- `potential` output, POT_WIDTH bits: current membrane potential, for debug.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE when the TSTEPS-th step is accepted.
  - DONE → IDLE after one cycle, unconditionally, unless `start` is high; DONE → RUN on `start`.
- On `start` in any state:
  - `potential` = 0, step counter = 0, refractory counter = 0, `spike_count` = 0.
  - Enter RUN.
  - `start` wins over a simultaneous `sum_valid`; no step is accepted that cycle.
- Accept: `sum_valid & sum_ready`. Steps are counted only on accept; gaps in `sum_valid` stall without leak.
- Per accepted step with refractory counter = 0:
  - Computed in signed POT_WIDTH+2 bits: `t = v - (LEAK_SHIFT ? v>>LEAK_SHIFT : 0) + sext(sum_in)`.
  - If t < 0, v = 0.
  - If t > 2^POT_WIDTH-1, v saturates to the maximum.
  - Otherwise v = t.
  - If v_new >= THRESH: spike = 1, v = 0, refractory counter = REFRAC, `spike_count` increments.
- Per accepted step with refractory counter > 0:
  - `sum_in` is discarded.
  - v stays 0, spike = 0, refractory counter decrements.
- `spike_count` saturates at TSTEPS, which cannot be exceeded by construction.
- `done` asserts in DONE. Results (`spike_count`) hold until the next `start` or reset.
- In IDLE and DONE, `sum_valid` is ignored and `sum_ready` = 0.

## Timing
- Reset (`rst_n` low at an edge) forces state IDLE and every output 0: `spike`, `spike_valid`, `spike_count`, `busy`, `done`, `potential`. `sum_ready` = 0 as a consequence. Reset overrides `start`.
- Accept at edge N: `potential`, `spike`, `spike_valid`, and `spike_count` reflect that step in the cycle after N. `spike_valid` deasserts the next cycle unless another accept occurs.
- Throughput: one step per cycle with `sum_valid` held high.
- Last accept at edge N:
  - `busy` = 0 and `done` = 1 during cycle N+1.
  - `done` = 0 from cycle N+2 (IDLE).
- `start` mid-RUN: counters clear at that edge; the old window produces no `done`.
- `start` asserted during a DONE cycle: `done` stays high for that cycle; RUN begins next.

## Test plan
- Reset: hold `rst_n` low 3 cycles with `start` and `sum_valid` high. Expect all outputs 0 and `sum_ready` = 0 throughout, then state IDLE after release.
- Defaults, `sum_in` = 40 held for 16 steps:
  - v = 40, then 75 → spike at step 2, v = 0.
  - Steps 3 and 4 are refractory.
  - Spikes occur at steps 2, 6, 10, 14.
  - `spike_count` = 4, with `done` 1 cycle after step 16.
- Negative input, `sum_in` = -20 for 16 steps: `potential` stays 0, no spikes, `spike_count` = 0.
- Saturation, with THRESH = 4095, LEAK_SHIFT = 0, TSTEPS = 40, `sum_in` = 127:
  - `potential` = 127·k for steps 1 to 32, e.g. 4064 at step 32.
  - At step 33, `potential` clamps to 4095 and fires, then 0.
  - No wrap-around at any step.
- Backpressure, `sum_in` = 40 with `sum_valid` toggled 1,0,0,1: `potential` 40 → held 40 → 75 with spike. The step count includes only accepted cycles.
- Restart: assert `start` after step 5 of the default run with `sum_valid` high in the same cycle. Expect that cycle not accepted, `spike_count` = 0, `potential` = 0, and a fresh 16-step window ending with `done`.
